// File: rtl/pe_pkg.sv
// pe_pkg -- shared definitions for the XNOR-popcount processing element.
//   pe_acc_state_t : accumulator sequencing states (IDLE, HELD, FULL)
//   pcnt_w()       : width needed to hold a popcount of SIMD bits
//   sat_add()      : unsigned add clamped to 2^w-1 (w up to 31)
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a popcount
    HELD = 2'd1,  // popcount held, waiting to be accumulated
    FULL = 2'd2   // all folds accumulated, waiting to binarize
  } pe_acc_state_t;

  function automatic int pcnt_w(input int simd);
    return $clog2(simd + 1);
  endfunction

  // Both operands arrive zero-extended to 32 bits; the 33-bit sum cannot
  // overflow, so a single compare against the limit is enough.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/pe_popcount.sv
// pe_popcount -- combinational XNOR popcount as a balanced adder tree.
//   act  in  SIMD    : binary activations
//   wgt  in  SIMD    : binary weights
//   pcnt out PCNT_W  : number of bit positions where act == wgt
// Leaves are padded with zeros up to the next power of two; every level of
// the tree lives in its own generate scope so no array feeds back on itself.
module pe_popcount
  import pe_pkg::*;
#(
  parameter int SIMD   = 32,
  parameter int PCNT_W = pcnt_w(SIMD)
) (
  input  logic [SIMD-1:0]   act,
  input  logic [SIMD-1:0]   wgt,
  output logic [PCNT_W-1:0] pcnt
);

  localparam int LEVELS = $clog2(SIMD);
  localparam int LEAVES = 1 << LEVELS;

  logic [SIMD-1:0] match_vec;
  assign match_vec = ~(act ^ wgt);

  genvar gi, gj;
  generate
    for (gi = 0; gi <= LEVELS; gi++) begin : g_lvl
      localparam int NODES = LEAVES >> gi;
      logic [PCNT_W-1:0] sum [NODES];
      for (gj = 0; gj < NODES; gj++) begin : g_node
        if (gi == 0) begin : g_leaf
          if (gj < SIMD) begin : g_bit
            assign sum[gj] = PCNT_W'(match_vec[gj]);
          end else begin : g_pad
            assign sum[gj] = '0;
          end
        end else begin : g_add
          // A subtree sum never exceeds SIMD, so PCNT_W bits cannot overflow.
          assign sum[gj] = g_lvl[gi-1].sum[2*gj] + g_lvl[gi-1].sum[2*gj+1];
        end
      end
    end
  endgenerate

  assign pcnt = g_lvl[LEVELS].sum[0];

endmodule

// File: rtl/pe_xnor_acc.sv
// pe_xnor_acc -- XNOR-popcount, fold accumulation and threshold binarization
// for one processing element, driven by strobes from the PE controller.
//   clk, rst (async, active low)
//   continuePcnt, actWord, wgtWord : capture popcount of ~(act ^ wgt)
//   continueAcc, numFolds          : accumulate held popcount (saturating)
//   binarizeStart, thr0, thr1      : compare accumulator and emit result
//   pcntDone, accDone, binValid    : one-cycle completion pulses
//   binOut                         : result, held until the next binValid
//   protoErr                       : sticky illegal-strobe flag
// Macro PE_RESIDUAL_EN: enables the second (residual) output bit using thr1;
// without it thr1 is unused and binOut[1] is always 0.
module pe_xnor_acc
  import pe_pkg::*;
#(
  parameter int SIMD   = 32,
  parameter int ACC_W  = 16,
  parameter int FOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              continuePcnt,
  input  logic [SIMD-1:0]   actWord,
  input  logic [SIMD-1:0]   wgtWord,
  input  logic              continueAcc,
  input  logic [FOLD_W-1:0] numFolds,
  input  logic              binarizeStart,
  input  logic [ACC_W-1:0]  thr0,
  input  logic [ACC_W-1:0]  thr1,
  output logic              pcntDone,
  output logic              accDone,
  output logic [1:0]        binOut,
  output logic              binValid,
  output logic              protoErr
);

  localparam int PCNT_W = pcnt_w(SIMD);

  pe_acc_state_t     state_reg;
  logic [PCNT_W-1:0] pcnt_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic [FOLD_W-1:0] fold_cnt_reg;
  logic [FOLD_W-1:0] num_folds_reg;

  logic [PCNT_W-1:0] pcnt_next;

  pe_popcount #(
    .SIMD   (SIMD),
    .PCNT_W (PCNT_W)
  ) u_popcount (
    .act  (actWord),
    .wgt  (wgtWord),
    .pcnt (pcnt_next)
  );

  // Fold bookkeeping. numFolds is only looked at on the first accumulate of
  // a neuron; that same cycle must already compare against it, so the
  // target bypasses the latch while the counter is still zero.
  logic [FOLD_W-1:0] folds_eff;
  logic [FOLD_W-1:0] fold_tgt;
  logic [FOLD_W-1:0] fold_inc;
  logic              last_fold;

  assign folds_eff = (numFolds == '0) ? FOLD_W'(1) : numFolds;
  assign fold_tgt  = (fold_cnt_reg == '0) ? folds_eff : num_folds_reg;
  assign fold_inc  = fold_cnt_reg + FOLD_W'(1);
  assign last_fold = (fold_inc == fold_tgt);

  logic [1:0] bin_next;

`ifdef PE_RESIDUAL_EN
  // One extra bit keeps thr0 + thr1 and acc + thr1 from wrapping.
  logic [ACC_W:0] acc_ext;
  logic [ACC_W:0] thr0_ext;
  logic [ACC_W:0] thr1_ext;
  logic           bin_hi;
  logic           bin_lo;

  assign acc_ext  = {1'b0, acc_reg};
  assign thr0_ext = {1'b0, thr0};
  assign thr1_ext = {1'b0, thr1};
  assign bin_lo   = (acc_ext >= thr0_ext);
  assign bin_hi   = bin_lo ? (acc_ext >= thr0_ext + thr1_ext)
                           : (acc_ext + thr1_ext >= thr0_ext);
  assign bin_next = {bin_hi, bin_lo};
`else
  logic unused_thr1;
  assign unused_thr1 = ^thr1;
  assign bin_next    = {1'b0, (acc_reg >= thr0)};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      pcnt_reg      <= '0;
      acc_reg       <= '0;
      fold_cnt_reg  <= '0;
      num_folds_reg <= '0;
      pcntDone      <= 1'b0;
      accDone       <= 1'b0;
      binOut        <= 2'b00;
      binValid      <= 1'b0;
      protoErr      <= 1'b0;
    end else begin
      pcntDone <= 1'b0;
      accDone  <= 1'b0;
      binValid <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (continuePcnt) begin
            pcnt_reg  <= pcnt_next;
            pcntDone  <= 1'b1;
            state_reg <= HELD;
          end
          // Nothing is held, so there is nothing to accumulate.
          if (continueAcc) begin
            protoErr <= 1'b1;
          end
        end

        HELD: begin
          if (continueAcc) begin
            acc_reg      <= ACC_W'(sat_add(32'(acc_reg), 32'(pcnt_reg), ACC_W));
            fold_cnt_reg <= fold_inc;
            if (fold_cnt_reg == '0) begin
              num_folds_reg <= folds_eff;
            end
            if (last_fold) begin
              state_reg <= FULL;
              accDone   <= 1'b1;
              // A popcount arriving with the final fold has nowhere to go.
              if (continuePcnt) begin
                protoErr <= 1'b1;
              end
            end else if (continuePcnt) begin
              pcnt_reg <= pcnt_next;
              pcntDone <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end else if (continuePcnt) begin
            // Overwrites a popcount that was never accumulated.
            pcnt_reg <= pcnt_next;
            pcntDone <= 1'b1;
            protoErr <= 1'b1;
          end
        end

        FULL: begin
          if (continuePcnt || continueAcc) begin
            protoErr <= 1'b1;
          end
          if (binarizeStart) begin
            binOut       <= bin_next;
            binValid     <= 1'b1;
            acc_reg      <= '0;
            fold_cnt_reg <= '0;
            state_reg    <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase

      if (binarizeStart && (state_reg != FULL)) begin
        protoErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pe_xnor_acc.sv
// tb_pe_xnor_acc -- scoreboard bench for pe_xnor_acc.
// ACC_W is reduced to 8 so that saturation is reachable within the 8-bit
// fold count; all other scenarios fit comfortably below 255.
module tb_pe_xnor_acc;

  localparam int SIMD    = 32;
  localparam int ACC_W   = 8;
  localparam int FOLD_W  = 8;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic              clk;
  logic              rst;
  logic              continuePcnt;
  logic [SIMD-1:0]   actWord;
  logic [SIMD-1:0]   wgtWord;
  logic              continueAcc;
  logic [FOLD_W-1:0] numFolds;
  logic              binarizeStart;
  logic [ACC_W-1:0]  thr0;
  logic [ACC_W-1:0]  thr1;
  logic              pcntDone;
  logic              accDone;
  logic [1:0]        binOut;
  logic              binValid;
  logic              protoErr;

  pe_xnor_acc #(
    .SIMD   (SIMD),
    .ACC_W  (ACC_W),
    .FOLD_W (FOLD_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .continuePcnt  (continuePcnt),
    .actWord       (actWord),
    .wgtWord       (wgtWord),
    .continueAcc   (continueAcc),
    .numFolds      (numFolds),
    .binarizeStart (binarizeStart),
    .thr0          (thr0),
    .thr1          (thr1),
    .pcntDone      (pcntDone),
    .accDone       (accDone),
    .binOut        (binOut),
    .binValid      (binValid),
    .protoErr      (protoErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Expected pulse cycles and binarized values.
  int         pcnt_q[$];
  int         acc_q[$];
  int         bin_cyc_q[$];
  logic [1:0] bin_val_q[$];

  // Per-neuron values copied onto the ports by every drive() call.
  logic [FOLD_W-1:0] nf_v;
  logic [ACC_W-1:0]  thr0_v;
  logic [ACC_W-1:0]  thr1_v;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=pulse required=none (t=%0t)", name, $time);
  endtask

  // Reference binarization with plain integer arithmetic.
  function automatic logic [1:0] model_bin(input int acc, input int t0, input int t1);
    logic b0;
    logic b1;
    b0 = (acc >= t0);
`ifdef PE_RESIDUAL_EN
    b1 = b0 ? (acc >= t0 + t1) : (acc + t1 >= t0);
`else
    b1 = 1'b0;
`endif
    return {b1, b0};
  endfunction

  task automatic drive(input logic p, input logic a, input logic b,
                       input logic [SIMD-1:0] aw, input logic [SIMD-1:0] ww);
    @(posedge clk);
    #1;
    continuePcnt  = p;
    continueAcc   = a;
    binarizeStart = b;
    actWord       = aw;
    wgtWord       = ww;
    numFolds      = nf_v;
    thr0          = thr0_v;
    thr1          = thr1_v;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // One complete neuron. t0/t1 < 0 pick thresholds at random (t0 biased to
  // land on or next to the expected accumulator value).
  task automatic run_neuron(input int nf, input bit overlap, input int t0, input int t1,
                            input bit fixed, input logic [SIMD-1:0] fa, input logic [SIMD-1:0] fw);
    logic [SIMD-1:0] aw_a[$];
    logic [SIMD-1:0] ww_a[$];
    logic [SIMD-1:0] aw;
    logic [SIMD-1:0] ww;
    int folds;
    int total;
    int acc_exp;
    int th0;
    int th1;
    int sel;
    folds = (nf == 0) ? 1 : nf;
    total = 0;
    for (int k = 0; k < folds; k++) begin
      aw = fixed ? fa : SIMD'($urandom);
      if (fixed) ww = fw;
      else if ($urandom_range(0, 3) == 0) ww = aw ^ SIMD'($urandom_range(0, 255));
      else ww = SIMD'($urandom);
      aw_a.push_back(aw);
      ww_a.push_back(ww);
      total += $countones(~(aw ^ ww));
    end
    acc_exp = (total > ACC_MAX) ? ACC_MAX : total;
    if (t0 < 0) begin
      sel = int'($urandom_range(0, 2));
      if (sel == 0) th0 = acc_exp;
      else if (sel == 1) th0 = (acc_exp == ACC_MAX) ? ACC_MAX : acc_exp + 1;
      else th0 = int'($urandom_range(0, ACC_MAX));
    end else begin
      th0 = t0;
    end
    th1 = (t1 < 0) ? int'($urandom_range(0, ACC_MAX / 4)) : t1;
    nf_v   = FOLD_W'(nf);
    thr0_v = ACC_W'(th0);
    thr1_v = ACC_W'(th1);

    if (overlap) begin
      drive(1'b1, 1'b0, 1'b0, aw_a[0], ww_a[0]);
      pcnt_q.push_back(cyc + 1);
      for (int k = 1; k < folds; k++) begin
        drive(1'b1, 1'b1, 1'b0, aw_a[k], ww_a[k]);
        pcnt_q.push_back(cyc + 1);
      end
      drive(1'b0, 1'b1, 1'b0, '0, '0);
      acc_q.push_back(cyc + 1);
    end else begin
      for (int k = 0; k < folds; k++) begin
        drive(1'b1, 1'b0, 1'b0, aw_a[k], ww_a[k]);
        pcnt_q.push_back(cyc + 1);
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        if (k == folds - 1) acc_q.push_back(cyc + 1);
      end
    end
    idle(int'($urandom_range(0, 2)));
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    bin_cyc_q.push_back(cyc + 1);
    bin_val_q.push_back(model_bin(acc_exp, th0, th1));
  endtask

  // Monitor: every output pulse must match the head of its queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (pcntDone) begin
          if (pcnt_q.size() == 0) unexpected("pcntDone_extra");
          else check("pcntDone_cycle", cyc, pcnt_q.pop_front());
        end
        if (accDone) begin
          if (acc_q.size() == 0) unexpected("accDone_extra");
          else check("accDone_cycle", cyc, acc_q.pop_front());
        end
        if (binValid) begin
          if (bin_cyc_q.size() == 0) unexpected("binValid_extra");
          else begin
            check("binValid_cycle", cyc, bin_cyc_q.pop_front());
            check("binOut", int'(binOut), int'(bin_val_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    continuePcnt = 1'b0; continueAcc = 1'b0; binarizeStart = 1'b0;
    actWord = '0; wgtWord = '0; numFolds = '0; thr0 = '0; thr1 = '0;
    nf_v = '0; thr0_v = '0; thr1_v = '0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pcntDone", int'(pcntDone), 0);
    check("rst_accDone",  int'(accDone),  0);
    check("rst_binOut",   int'(binOut),   0);
    check("rst_binValid", int'(binValid), 0);
    check("rst_protoErr", int'(protoErr), 0);
    rst = 1'b1;

    // 3 folds of popcount 16 -> 48.
    run_neuron(3, 1'b1, 40, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_0000);
    run_neuron(3, 1'b1, 49, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_0000);
    // Immediate new neuron, act == wgt -> 32.
    run_neuron(1, 1'b1, 32, 0, 1'b1, 32'h1234_5678, 32'h1234_5678);
    // 9 x 32 = 288 saturates at 255.
    run_neuron(9, 1'b1, ACC_MAX, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    // numFolds == 0 behaves as one fold (16).
    run_neuron(0, 1'b0, 16, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_0000);
    run_neuron(0, 1'b1, 17, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_0000);
    idle(2);

    repeat (150) begin
      run_neuron(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), -1, -1, 1'b0, '0, '0);
    end
    idle(3);
    check("protoErr_clean", int'(protoErr), 0);

    // binarizeStart in IDLE: ignored, flags an error.
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    idle(3);
    check("protoErr_bin_idle", int'(protoErr), 1);

    // Strobes in FULL must not disturb the accumulator (16 < 17 -> 0).
    nf_v = FOLD_W'(1); thr0_v = ACC_W'(17); thr1_v = '0;
    drive(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_0000);
    pcnt_q.push_back(cyc + 1);
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    acc_q.push_back(cyc + 1);
    drive(1'b1, 1'b1, 1'b0, 32'h5, 32'h5);
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    bin_cyc_q.push_back(cyc + 1);
    bin_val_q.push_back(model_bin(16, 17, 0));
    idle(2);
    check("protoErr_sticky", int'(protoErr), 1);

    // Leave binOut at 01 before the reset test.
    run_neuron(1, 1'b1, 16, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_0000);
    idle(2);

    // Reset in the middle of a 3-fold neuron.
    nf_v = FOLD_W'(3); thr0_v = '0; thr1_v = '0;
    drive(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    pcnt_q.push_back(cyc + 1);
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    pcnt_q.push_back(cyc + 1);
    idle(2);
    rst = 1'b0;
    #2;
    check("midrst_pcntDone", int'(pcntDone), 0);
    check("midrst_accDone",  int'(accDone),  0);
    check("midrst_binOut",   int'(binOut),   0);
    check("midrst_binValid", int'(binValid), 0);
    check("midrst_protoErr", int'(protoErr), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Partial accumulation must be gone: 32 < 33 -> 0, then 32 >= 32 -> 1.
    run_neuron(1, 1'b1, 33, 0, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    run_neuron(1, 1'b0, 32, 0, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    idle(4);

    check("pending_pcntDone", pcnt_q.size(), 0);
    check("pending_accDone",  acc_q.size(),  0);
    check("pending_binValid", bin_cyc_q.size(), 0);
    check("protoErr_after_rst", int'(protoErr), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
